calc_controller: RTL and testbench

Main sequencing FSM of the FPGA calculator. Consumes validated keypad codes and builds the two 4-digit BCD operands. Latches the operation, then launches the ALU through a start/done handshake. Its `curr_state`, `num1_bcd`, `num2_bcd` and `operation` outputs drive the display mux, which selects the value shown per state.

---
 rtl/calc_controller.sv | 191 +++++++++++++++++++
 tb/tb_calc_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controller.sv
// Calculator sequencing FSM: builds two BCD operands from keypad codes, launches the ALU and
// tracks completion or timeout. Define CALC_CHAIN_EN to let an operator after a result chain it.
module calc_controller #(
  parameter int ALU_TIMEOUT = 1023,
  parameter int DIGITS      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                key_ready,
  output logic [1:0]          curr_state,
  output logic [4*DIGITS-1:0] num1_bcd,
  output logic [4*DIGITS-1:0] num2_bcd,
  output logic [1:0]          operation,
  output logic                alu_start,
  input  logic                alu_done,
  input  logic                alu_err,
  input  logic [4*DIGITS-1:0] alu_result,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    ST_N1 = 2'b00,
    ST_OP = 2'b01,
    ST_N2 = 2'b10,
    ST_EQ = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    num1_q, num1_d;
  logic [W-1:0]    num2_q, num2_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pending_q, pending_d;
  logic            err_q, err_d;
  logic            alu_start_q, alu_start_d;
  logic            key_ready_q, key_ready_d;

  logic            accept, is_digit, is_op, is_eq, is_clr, can_shift;
  logic [3:0]      op_code;

  // Clear bypasses key_ready so a hung ALU can always be abandoned.
  assign is_digit  = (key_code <= 4'd9);
  assign is_op     = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq     = (key_code == 4'd14);
  assign is_clr    = (key_code == 4'd15);
  assign accept    = key_valid && (key_ready_q || is_clr);
  assign op_code   = key_code - 4'd10;
  assign can_shift = (cnt_q < CW'(DIGITS));

`ifndef CALC_CHAIN_EN
  logic unused_result;
  assign unused_result = ^alu_result;
`endif

  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    pending_d   = pending_q;
    err_d       = err_q;
    alu_start_d = 1'b0;
    key_ready_d = key_ready_q;

    // Completion beats timeout when both land on the same cycle.
    if (pending_q) begin
      if (alu_done) begin
        pending_d   = 1'b0;
        key_ready_d = 1'b1;
        err_d       = alu_err;
      end else if (tmo_q >= TW'(ALU_TIMEOUT - 1)) begin
        pending_d   = 1'b0;
        key_ready_d = 1'b1;
        err_d       = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (accept) begin
      if (is_clr) begin
        state_d     = ST_N1;
        num1_d      = '0;
        num2_d      = '0;
        op_d        = '0;
        cnt_d       = '0;
        tmo_d       = '0;
        pending_d   = 1'b0;
        err_d       = 1'b0;
        alu_start_d = 1'b0;
        key_ready_d = 1'b1;
      end else begin
        unique case (state_q)
          ST_N1: begin
            if (is_digit && can_shift) begin
              num1_d = {num1_q[W-5:0], key_code};
              cnt_d  = cnt_q + CW'(1);
            end else if (is_op) begin
              op_d    = op_code[1:0];
              state_d = ST_OP;
            end
          end
          ST_OP: begin
            if (is_op) begin
              op_d = op_code[1:0];
            end else if (is_digit) begin
              num2_d  = W'(key_code);
              cnt_d   = CW'(1);
              state_d = ST_N2;
            end
          end
          ST_N2: begin
            if (is_digit && can_shift) begin
              num2_d = {num2_q[W-5:0], key_code};
              cnt_d  = cnt_q + CW'(1);
            end else if (is_eq) begin
              alu_start_d = 1'b1;
              pending_d   = 1'b1;
              key_ready_d = 1'b0;
              tmo_d       = '0;
              state_d     = ST_EQ;
            end
          end
          ST_EQ: begin
            if (is_digit) begin
              num1_d  = W'(key_code);
              num2_d  = '0;
              cnt_d   = CW'(1);
              err_d   = 1'b0;
              state_d = ST_N1;
            end
`ifdef CALC_CHAIN_EN
            else if (is_op && !err_q) begin
              num1_d  = alu_result;
              num2_d  = '0;
              op_d    = op_code[1:0];
              cnt_d   = '0;
              state_d = ST_OP;
            end
`endif
          end
          default: state_d = ST_N1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_N1;
      num1_q      <= '0;
      num2_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      pending_q   <= pending_d;
      err_q       <= err_d;
      alu_start_q <= alu_start_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign curr_state = state_q;
  assign num1_bcd   = num1_q;
  assign num2_bcd   = num2_q;
  assign operation  = op_q;
  assign alu_start  = alu_start_q;
  assign key_ready  = key_ready_q;
  assign err        = err_q;

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller: stimulus queues expected snapshots and launches,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_calc_controller;
  localparam int TO = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [1:0]  curr_state;
  logic [15:0] num1_bcd, num2_bcd;
  logic [1:0]  operation;
  logic        alu_start, alu_done, alu_err;
  logic [15:0] alu_result;
  logic        err;

  always #5 clk = ~clk;

  calc_controller #(.ALU_TIMEOUT(TO), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .curr_state(curr_state), .num1_bcd(num1_bcd),
    .num2_bcd(num2_bcd), .operation(operation), .alu_start(alu_start),
    .alu_done(alu_done), .alu_err(alu_err), .alu_result(alu_result), .err(err)
  );

  typedef struct {
    logic [1:0]  st;
    logic [15:0] n1, n2;
    logic [1:0]  op;
    logic        kr, er, start;
  } exp_t;

  typedef struct {
    logic [15:0] n1, n2;
    logic [1:0]  op;
  } launch_t;

  exp_t    exp_q[$];
  string   name_q[$];
  launch_t launch_q[$];
  int      n_chk = 0;
  int      n_fail = 0;
  int      n_launch = 0;
  logic    start_prev = 1'b0;

  // Monitor: compares queued snapshots and every alu_start pulse.
  always @(negedge clk) begin
    #1;
    while (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if ({curr_state, num1_bcd, num2_bcd, operation, key_ready, err, alu_start} !==
          {e.st, e.n1, e.n2, e.op, e.kr, e.er, e.start}) begin
        n_fail++;
        $display("FAIL %s: got st=%0d n1=%h n2=%h op=%0d kr=%b err=%b start=%b, want st=%0d n1=%h n2=%h op=%0d kr=%b err=%b start=%b",
                 nm, curr_state, num1_bcd, num2_bcd, operation, key_ready, err, alu_start,
                 e.st, e.n1, e.n2, e.op, e.kr, e.er, e.start);
      end
    end
    if (start_prev) begin
      n_chk++;
      if (alu_start !== 1'b0) begin
        n_fail++;
        $display("FAIL start_width: alu_start=%b on cycle after launch, want 0", alu_start);
      end
    end
    if (alu_start === 1'b1) begin
      n_chk++;
      n_launch++;
      if (launch_q.size() == 0) begin
        n_fail++;
        $display("FAIL launch_unexpected: alu_start=1 with no launch expected");
      end else begin
        launch_t l;
        l = launch_q.pop_front();
        if ({num1_bcd, num2_bcd, operation} !== {l.n1, l.n2, l.op}) begin
          n_fail++;
          $display("FAIL launch_operands: got n1=%h n2=%h op=%0d, want n1=%h n2=%h op=%0d",
                   num1_bcd, num2_bcd, operation, l.n1, l.n2, l.op);
        end
      end
    end
    start_prev <= (alu_start === 1'b1);
  end

  task automatic chk(input string nm, input logic [1:0] st, input logic [15:0] n1,
                     input logic [15:0] n2, input logic [1:0] op, input logic kr,
                     input logic er, input logic start);
    exp_t e;
    e.st = st; e.n1 = n1; e.n2 = n2; e.op = op; e.kr = kr; e.er = er; e.start = start;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic exp_launch(input logic [15:0] n1, input logic [15:0] n2, input logic [1:0] op);
    launch_t l;
    l.n1 = n1; l.n2 = n2; l.op = op;
    launch_q.push_back(l);
  endtask

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic e, input logic [15:0] r);
    @(negedge clk);
    alu_done   = 1'b1;
    alu_err    = e;
    alu_result = r;
    @(negedge clk);
    alu_done   = 1'b0;
    alu_err    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    alu_done = 1'b0; alu_err = 1'b0; alu_result = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_held", 2'd0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset", 2'd0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Digit entry and saturation at four digits
    key(4'd1); key(4'd2); key(4'd3);
    chk("n1_123", 2'd0, 16'h0123, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd15);
    chk("clear_n1", 2'd0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd4); key(4'd5); key(4'd6); key(4'd7);
    chk("n1_4567", 2'd0, 16'h4567, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd8);
    chk("n1_5th_drop", 2'd0, 16'h4567, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd15);
    key(4'd14);
    chk("eq_in_n1", 2'd0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Operator overwrite, second operand, launch
    key(4'd1);
    chk("n1_1", 2'd0, 16'h0001, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd10);
    chk("op_add", 2'd1, 16'h0001, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd11);
    chk("op_sub", 2'd1, 16'h0001, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0);
    key(4'd2);
    chk("n2_2", 2'd2, 16'h0001, 16'h0002, 2'd1, 1'b1, 1'b0, 1'b0);
    exp_launch(16'h0001, 16'h0002, 2'd1);
    key(4'd14);
    chk("launch1", 2'd3, 16'h0001, 16'h0002, 2'd1, 1'b0, 1'b0, 1'b1);
    key(4'd7);
    chk("key_dropped", 2'd3, 16'h0001, 16'h0002, 2'd1, 1'b0, 1'b0, 1'b0);
    done_pulse(1'b1, 16'h0000);
    chk("done_err", 2'd3, 16'h0001, 16'h0002, 2'd1, 1'b1, 1'b1, 1'b0);
    key(4'd9);
    chk("restart_9", 2'd0, 16'h0009, 16'h0000, 2'd1, 1'b1, 1'b0, 1'b0);

    // Timeout, then a late done is ignored
    key(4'd13);
    chk("op_div", 2'd1, 16'h0009, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b0);
    key(4'd5);
    chk("n2_5", 2'd2, 16'h0009, 16'h0005, 2'd3, 1'b1, 1'b0, 1'b0);
    exp_launch(16'h0009, 16'h0005, 2'd3);
    key(4'd14);
    chk("launch2", 2'd3, 16'h0009, 16'h0005, 2'd3, 1'b0, 1'b0, 1'b1);
    repeat (TO - 5) @(negedge clk);
    chk("pending_hold", 2'd3, 16'h0009, 16'h0005, 2'd3, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    chk("timeout", 2'd3, 16'h0009, 16'h0005, 2'd3, 1'b1, 1'b1, 1'b0);
    done_pulse(1'b0, 16'h9999);
    chk("late_done", 2'd3, 16'h0009, 16'h0005, 2'd3, 1'b1, 1'b1, 1'b0);
    key(4'd10);
    chk("op_after_err", 2'd3, 16'h0009, 16'h0005, 2'd3, 1'b1, 1'b1, 1'b0);

    // Clear and done on the same cycle
    key(4'd3);
    chk("restart_3", 2'd0, 16'h0003, 16'h0000, 2'd3, 1'b1, 1'b0, 1'b0);
    key(4'd10);
    key(4'd4);
    chk("n2_4", 2'd2, 16'h0003, 16'h0004, 2'd0, 1'b1, 1'b0, 1'b0);
    exp_launch(16'h0003, 16'h0004, 2'd0);
    key(4'd14);
    chk("launch3", 2'd3, 16'h0003, 16'h0004, 2'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd15; alu_done = 1'b1; alu_err = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; alu_done = 1'b0; alu_err = 1'b0;
    chk("clear_vs_done", 2'd0, 16'h0000, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Result chaining
    key(4'd2); key(4'd10); key(4'd6);
    key(4'd11);
    chk("op_in_n2", 2'd2, 16'h0002, 16'h0006, 2'd0, 1'b1, 1'b0, 1'b0);
    exp_launch(16'h0002, 16'h0006, 2'd0);
    key(4'd14);
    chk("launch4", 2'd3, 16'h0002, 16'h0006, 2'd0, 1'b0, 1'b0, 1'b1);
    done_pulse(1'b0, 16'h0042);
    chk("done_ok", 2'd3, 16'h0002, 16'h0006, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd12);
`ifdef CALC_CHAIN_EN
    chk("chain", 2'd1, 16'h0042, 16'h0000, 2'd2, 1'b1, 1'b0, 1'b0);
    key(4'd3);
    chk("chain_n2", 2'd2, 16'h0042, 16'h0003, 2'd2, 1'b1, 1'b0, 1'b0);
`else
    chk("no_chain", 2'd3, 16'h0002, 16'h0006, 2'd0, 1'b1, 1'b0, 1'b0);
    key(4'd3);
    chk("no_chain_digit", 2'd0, 16'h0003, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if (launch_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_drained: launch_q=%0d exp_q=%0d left, want 0", launch_q.size(), exp_q.size());
    end
    n_chk++;
    if (n_launch != 4) begin
      n_fail++;
      $display("FAIL launch_count: got %0d alu_start pulses, want 4", n_launch);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
